// File: rtl/key_entry_conditioner.sv
// key_entry_conditioner
// Conditions the raw active-low pushbuttons into clean levels and single-cycle
// press/release events, then uses those events to capture an amount/key pair
// from the slide switches and offer it downstream with a valid/ready handshake.
module key_entry_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 19,
  parameter int SW_WIDTH        = 8,
  parameter int LOAD_IDX        = 1,
  parameter int CANCEL_IDX      = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [SW_WIDTH-1:0] sw,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_press_pulse,
  output logic [NUM_KEYS-1:0] key_release_pulse,
  output logic [SW_WIDTH-1:0] entry_amount,
  output logic [SW_WIDTH-1:0] entry_key,
  output logic                entry_valid,
  input  logic                entry_ready,
  output logic [1:0]          entry_stage
);

  typedef enum logic [1:0] {
    AWAIT_AMOUNT = 2'd0,
    AWAIT_KEY    = 2'd1,
    FULL         = 2'd2
  } stage_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0]  sync1_q, sync1_d;
  logic [NUM_KEYS-1:0]  sync2_q, sync2_d;
  logic [NUM_KEYS-1:0]  key_level;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_KEYS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0]  pressed_q, pressed_d;
  logic [NUM_KEYS-1:0]  press_pulse_q, press_pulse_d;
  logic [NUM_KEYS-1:0]  release_pulse_q, release_pulse_d;

  stage_e               state_q, state_d;
  logic [SW_WIDTH-1:0]  amount_q, amount_d;
  logic [SW_WIDTH-1:0]  key_q, key_d;
  logic                 valid_q, valid_d;
  logic                 load_evt;
  logic                 cancel_evt;

  // Two-stage synchroniser, debounce counters and edge pulses for every key.
  always_comb begin
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    key_level = ~sync2_q;
    pressed_d = pressed_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = '0;
      if (key_level[i] != pressed_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          pressed_d[i] = ~pressed_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    press_pulse_d   = pressed_d & ~pressed_q;
    release_pulse_d = ~pressed_d & pressed_q;
  end

  // Registers for the key conditioning path; released keys are the idle state.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q         <= '1;
      sync2_q         <= '1;
      pressed_q       <= '0;
      press_pulse_q   <= '0;
      release_pulse_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Entry sequencer: LOAD captures amount then key, CANCEL always restarts.
  always_comb begin
    state_d    = state_q;
    amount_d   = amount_q;
    key_d      = key_q;
    valid_d    = valid_q;
    load_evt   = press_pulse_q[LOAD_IDX];
    cancel_evt = press_pulse_q[CANCEL_IDX];
    case (state_q)
      AWAIT_AMOUNT: begin
        if (load_evt) begin
          amount_d = sw;
          state_d  = AWAIT_KEY;
        end
      end
      AWAIT_KEY: begin
        if (load_evt) begin
          key_d   = sw;
          state_d = FULL;
          valid_d = 1'b1;
        end
      end
      FULL: begin
        if (valid_q && entry_ready) begin
          valid_d = 1'b0;
          state_d = AWAIT_AMOUNT;
        end
      end
      default: begin
        state_d = AWAIT_AMOUNT;
        valid_d = 1'b0;
      end
    endcase
    if (cancel_evt) begin
      state_d  = AWAIT_AMOUNT;
      valid_d  = 1'b0;
      amount_d = amount_q;
      key_d    = key_q;
    end
  end

  // Sequencer state and captured pair.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= AWAIT_AMOUNT;
      amount_q <= '0;
      key_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      amount_q <= amount_d;
      key_q    <= key_d;
      valid_q  <= valid_d;
    end
  end

  assign key_pressed       = pressed_q;
  assign key_press_pulse   = press_pulse_q;
  assign key_release_pulse = release_pulse_q;
  assign entry_amount      = amount_q;
  assign entry_key         = key_q;
  assign entry_valid       = valid_q;
  assign entry_stage       = state_q;

endmodule

// File: tb/tb_key_entry_conditioner.sv
// Testbench for key_entry_conditioner: directed test-plan steps followed by a
// randomized phase, all compared every cycle against a behavioural model.
module tb_key_entry_conditioner;

  localparam int D  = 4;
  localparam int NK = 4;
  localparam int SW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [SW-1:0] sw;
  logic          entry_ready;
  logic [NK-1:0] key_pressed;
  logic [NK-1:0] key_press_pulse;
  logic [NK-1:0] key_release_pulse;
  logic [SW-1:0] entry_amount;
  logic [SW-1:0] entry_key;
  logic          entry_valid;
  logic [1:0]    entry_stage;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [NK-1:0] hist [0:D+1];
  logic [NK-1:0] m_pressed;
  logic [NK-1:0] m_press;
  logic [NK-1:0] m_release;
  logic [SW-1:0] m_amount;
  logic [SW-1:0] m_key;
  logic          m_valid;
  int            m_stage;
  logic [NK-1:0] seen_press;
  logic [NK-1:0] seen_release;

  key_entry_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(3),
    .SW_WIDTH(SW), .LOAD_IDX(1), .CANCEL_IDX(3)
  ) dut (
    .clock(clock), .reset(reset), .key_n(key_n), .sw(sw),
    .key_pressed(key_pressed), .key_press_pulse(key_press_pulse),
    .key_release_pulse(key_release_pulse), .entry_amount(entry_amount),
    .entry_key(entry_key), .entry_valid(entry_valid),
    .entry_ready(entry_ready), .entry_stage(entry_stage)
  );

  // 10 ns clock
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model of one rising edge: a level is accepted once the synchronised input
  // (raw delayed by two samples) has disagreed with it for D consecutive cycles.
  task automatic modelEdge();
    logic [NK-1:0] newp;
    logic          load, cancel, all_differ;
    if (reset) begin
      for (int j = 0; j <= D + 1; j++) hist[j] = '1;
      m_pressed = '0; m_press = '0; m_release = '0;
      m_amount = '0; m_key = '0; m_valid = 1'b0; m_stage = 0;
    end else begin
      load   = m_press[1];
      cancel = m_press[3];
      if (cancel) begin
        m_stage = 0; m_valid = 1'b0;
      end else if (m_stage == 0 && load) begin
        m_amount = sw; m_stage = 1;
      end else if (m_stage == 1 && load) begin
        m_key = sw; m_stage = 2; m_valid = 1'b1;
      end else if (m_stage == 2 && entry_ready) begin
        m_valid = 1'b0; m_stage = 0;
      end
      for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = key_n;
      newp = m_pressed;
      for (int k = 0; k < NK; k++) begin
        all_differ = 1'b1;
        for (int j = 2; j <= D + 1; j++) begin
          if (hist[j][k] != m_pressed[k]) all_differ = 1'b0;
        end
        if (all_differ) newp[k] = ~m_pressed[k];
      end
      m_press   = newp & ~m_pressed;
      m_release = ~newp & m_pressed;
      m_pressed = newp;
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_pressed"}, 32'(key_pressed), 32'(m_pressed));
    check({tag, "_press_pulse"}, 32'(key_press_pulse), 32'(m_press));
    check({tag, "_release_pulse"}, 32'(key_release_pulse), 32'(m_release));
    check({tag, "_amount"}, 32'(entry_amount), 32'(m_amount));
    check({tag, "_key"}, 32'(entry_key), 32'(m_key));
    check({tag, "_valid"}, 32'(entry_valid), 32'(m_valid));
    check({tag, "_stage"}, 32'(entry_stage), 32'(m_stage));
  endtask

  // Advance n clocks with inputs held; model updates at the edge, outputs sampled at negedge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clock);
      modelEdge();
      @(negedge clock);
      seen_press   = seen_press | key_press_pulse;
      seen_release = seen_release | key_release_pulse;
      checkOutput("step");
    end
  endtask

  task automatic pressKey(input int idx, input int hold);
    key_n[idx] = 1'b0;
    applyStimulus(hold);
    key_n[idx] = 1'b1;
    applyStimulus(hold);
  endtask

  initial begin
    reset = 1'b1; key_n = '1; sw = '0; entry_ready = 1'b0;
    seen_press = '0; seen_release = '0;
    applyStimulus(2);
    reset = 1'b0;

    // 1: idle after reset
    seen_press = '0; seen_release = '0;
    applyStimulus(20);
    check("tp1_pressed", 32'(key_pressed), 32'h0);
    check("tp1_pulses", 32'({seen_press, seen_release}), 32'h0);
    check("tp1_stage", 32'(entry_stage), 32'h0);
    check("tp1_valid", 32'(entry_valid), 32'h0);

    // 2: clean press latency
    seen_press = '0;
    key_n[1] = 1'b0;
    applyStimulus(5);
    check("tp2_early", 32'(key_pressed), 32'h0);
    applyStimulus(1);
    check("tp2_rise", 32'(key_pressed), 32'h2);
    check("tp2_pulse", 32'(key_press_pulse), 32'h2);
    applyStimulus(1);
    check("tp2_pulse_gone", 32'(key_press_pulse), 32'h0);
    applyStimulus(6);
    check("tp2_one_pulse", 32'(seen_press), 32'h2);
    key_n[1] = 1'b1;
    applyStimulus(8);
    pressKey(3, 8);
    check("tp2_cancel_stage", 32'(entry_stage), 32'h0);

    // 3: bouncing key never accepted
    seen_press = '0; seen_release = '0;
    for (int t = 0; t < 10; t++) begin
      key_n[0] = ~key_n[0];
      applyStimulus(2);
    end
    key_n[0] = 1'b1;
    applyStimulus(10);
    check("tp3_pressed0", 32'(key_pressed[0]), 32'h0);
    check("tp3_pulses", 32'({seen_press, seen_release}), 32'h0);

    // 4: capture a pair and hand it off
    entry_ready = 1'b0;
    sw = 8'h2A; pressKey(1, 8);
    sw = 8'h5C; pressKey(1, 8);
    applyStimulus(50);
    check("tp4_amount", 32'(entry_amount), 32'h2A);
    check("tp4_key", 32'(entry_key), 32'h5C);
    check("tp4_valid", 32'(entry_valid), 32'h1);
    check("tp4_stage", 32'(entry_stage), 32'h2);
    entry_ready = 1'b1;
    applyStimulus(1);
    entry_ready = 1'b0;
    check("tp4_valid_drop", 32'(entry_valid), 32'h0);
    check("tp4_stage_idle", 32'(entry_stage), 32'h0);
    check("tp4_amount_kept", 32'(entry_amount), 32'h2A);

    // 5: cancel mid-entry then a fresh pair
    sw = 8'h11; pressKey(1, 8);
    check("tp5_amount", 32'(entry_amount), 32'h11);
    check("tp5_stage1", 32'(entry_stage), 32'h1);
    pressKey(3, 8);
    check("tp5_cancel", 32'(entry_stage), 32'h0);
    sw = 8'h22; pressKey(1, 8);
    sw = 8'h33; pressKey(1, 8);
    check("tp5_pair", 32'({entry_amount, entry_key}), 32'h2233);
    check("tp5_valid", 32'(entry_valid), 32'h1);

    // 6: LOAD ignored in FULL, then reset mid-debounce
    sw = 8'hFF; pressKey(1, 8);
    check("tp6_pair_held", 32'({entry_amount, entry_key}), 32'h2233);
    check("tp6_stage", 32'(entry_stage), 32'h2);
    key_n[1] = 1'b0;
    applyStimulus(3);
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    check("tp6_rst_outputs", 32'({key_pressed, key_press_pulse, key_release_pulse}), 32'h0);
    check("tp6_rst_pair", 32'({entry_amount, entry_key}), 32'h0);
    check("tp6_rst_entry", 32'({entry_valid, entry_stage}), 32'h0);
    seen_press = '0;
    applyStimulus(4);
    check("tp6_no_early_pulse", 32'(seen_press), 32'h0);
    applyStimulus(2);
    check("tp6_fresh_press", 32'(key_press_pulse), 32'h2);
    key_n[1] = 1'b1;
    applyStimulus(8);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(0, 9) == 0) key_n[k] = ~key_n[k];
      end
      sw          = SW'($urandom);
      entry_ready = ($urandom_range(0, 3) == 0);
      reset       = ($urandom_range(0, 249) == 0);
      applyStimulus(1);
    end
    reset = 1'b0;
    applyStimulus(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
